// File: rtl/ram_cache_pkg.sv
// Shared state encoding, geometry defaults and address-field helpers for the
// RAM line cache.
package ram_cache_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_REQ,
    ST_WR_ACK,
    ST_RF_REQ,
    ST_RF_ACK
  } cache_state_e;

  function automatic int off_w(input int line_words);
    return $clog2(line_words);
  endfunction

  function automatic int idx_w(input int lines);
    return $clog2(lines);
  endfunction

  function automatic int tag_w(input int lines, input int line_words);
    return 30 - $clog2(lines) - $clog2(line_words);
  endfunction

  localparam int DEF_LINES      = 64;
  localparam int DEF_LINE_WORDS = 4;
  localparam int DEF_OW         = off_w(DEF_LINE_WORDS);
  localparam int DEF_IW         = idx_w(DEF_LINES);
  localparam int DEF_TW         = tag_w(DEF_LINES, DEF_LINE_WORDS);

  // Field extractors take the widths explicitly so overridden geometries work.
  function automatic logic [31:0] addr_offset(input logic [31:0] addr, input int ow);
    return (addr >> 2) & ((32'd1 << ow) - 32'd1);
  endfunction

  function automatic logic [31:0] addr_index(input logic [31:0] addr, input int ow,
                                             input int iw);
    return (addr >> (2 + ow)) & ((32'd1 << iw) - 32'd1);
  endfunction

  function automatic logic [31:0] addr_tag(input logic [31:0] addr, input int ow,
                                           input int iw);
    return addr >> (2 + ow + iw);
  endfunction

  function automatic logic [31:0] line_base(input logic [31:0] addr, input int ow);
    return addr & ~((32'd1 << (2 + ow)) - 32'd1);
  endfunction

endpackage

// File: rtl/ram_cache_data.sv
// Byte-enabled, synchronous-read data array for the line cache. One write port
// shared between bridge write hits and refill fills.
module ram_cache_data
  import ram_cache_pkg::*;
#(
  parameter int DEPTH = DEF_LINES * DEF_LINE_WORDS,
  parameter int AW    = DEF_OW + DEF_IW
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          hit_we_i,
  input  logic [AW-1:0] hit_addr_i,
  input  logic [3:0]    hit_strb_i,
  input  logic [31:0]   hit_data_i,
  input  logic          fill_we_i,
  input  logic [AW-1:0] fill_addr_i,
  input  logic [31:0]   fill_data_i,
  input  logic          rd_en_i,
  input  logic [AW-1:0] rd_addr_i,
  output logic [31:0]   rd_data_o
);

  logic [31:0]   data_mem [DEPTH];
  logic          we;
  logic [AW-1:0] waddr;
  logic [3:0]    wstrb;
  logic [31:0]   wdata;
  logic [31:0]   rd_data_q, rd_data_d;

  // Fill and write-hit come from different FSM states, so they never collide.
  always_comb begin
    if (fill_we_i) begin
      we    = 1'b1;
      waddr = fill_addr_i;
      wstrb = 4'hF;
      wdata = fill_data_i;
    end else begin
      we    = hit_we_i;
      waddr = hit_addr_i;
      wstrb = hit_strb_i;
      wdata = hit_data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (we) begin
      for (int b = 0; b < 4; b++) begin
        if (wstrb[b]) data_mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  always_comb rd_data_d = rd_en_i ? data_mem[rd_addr_i] : rd_data_q;

  always_ff @(posedge clk_i) begin
    if (!rst_i) rd_data_q <= '0;
    else        rd_data_q <= rd_data_d;
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/ram_line_cache.sv
// Direct-mapped write-through line cache between the bridge RAM port and a
// variable-latency backing memory; read misses refill a whole line.
module ram_line_cache
  import ram_cache_pkg::*;
#(
  parameter int LINES      = DEF_LINES,
  parameter int LINE_WORDS = DEF_LINE_WORDS
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [3:0]  ram_wr_i,
  input  logic        ram_rd_i,
  input  logic [31:0] ram_addr_i,
  input  logic [31:0] ram_write_data_i,
  output logic        ram_accept_o,
  output logic [31:0] ram_read_data_o,
  output logic        mem_req_o,
  output logic [3:0]  mem_wr_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_accept_i,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_rdata_i
);

  localparam int OW = off_w(LINE_WORDS);
  localparam int IW = idx_w(LINES);
  localparam int TW = tag_w(LINES, LINE_WORDS);

  cache_state_e     state_q, state_d;
  logic [LINES-1:0] valid_q, valid_d;
  logic [TW-1:0]    tag_q [LINES];
  logic [TW-1:0]    tag_d [LINES];
  logic [OW-1:0]    cnt_q, cnt_d, cnt_next;
  logic [31:0]      base_q, base_d;
  logic             mem_req_q, mem_req_d;
  logic [3:0]       mem_wr_q, mem_wr_d;
  logic [31:0]      mem_addr_q, mem_addr_d;
  logic [31:0]      mem_wdata_q, mem_wdata_d;

  logic [OW-1:0] req_off;
  logic [IW-1:0] req_idx, fill_idx;
  logic [TW-1:0] req_tag, fill_tag;
  logic          req_hit, wr_req;
  logic          accept, hit_we, fill_we, rd_en;

  assign req_off  = OW'(addr_offset(ram_addr_i, OW));
  assign req_idx  = IW'(addr_index(ram_addr_i, OW, IW));
  assign req_tag  = TW'(addr_tag(ram_addr_i, OW, IW));
  assign fill_idx = IW'(addr_index(base_q, OW, IW));
  assign fill_tag = TW'(addr_tag(base_q, OW, IW));
  assign req_hit  = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
  assign wr_req   = |ram_wr_i;
  assign cnt_next = cnt_q + OW'(1);

  always_comb begin
    state_d     = state_q;
    valid_d     = valid_q;
    tag_d       = tag_q;
    cnt_d       = cnt_q;
    base_d      = base_q;
    mem_req_d   = mem_req_q;
    mem_wr_d    = mem_wr_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    accept      = 1'b0;
    hit_we      = 1'b0;
    fill_we     = 1'b0;
    rd_en       = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (wr_req) begin
          // The registered backend outputs double as the write buffer.
          accept      = 1'b1;
          hit_we      = req_hit;
          mem_req_d   = 1'b1;
          mem_wr_d    = ram_wr_i;
          mem_addr_d  = {ram_addr_i[31:2], 2'b00};
          mem_wdata_d = ram_write_data_i;
          state_d     = ST_WR_REQ;
        end else if (ram_rd_i && req_hit) begin
          accept = 1'b1;
          rd_en  = 1'b1;
        end else if (ram_rd_i) begin
          base_d     = line_base(ram_addr_i, OW);
          cnt_d      = '0;
          mem_req_d  = 1'b1;
          mem_wr_d   = 4'h0;
          mem_addr_d = line_base(ram_addr_i, OW);
          state_d    = ST_RF_REQ;
        end
      end
      ST_WR_REQ: begin
        if (mem_accept_i) begin
          mem_req_d = 1'b0;
          state_d   = ST_WR_ACK;
        end
      end
      ST_WR_ACK: begin
        if (mem_ack_i) state_d = ST_IDLE;
      end
      ST_RF_REQ: begin
        if (mem_accept_i) begin
          mem_req_d = 1'b0;
          state_d   = ST_RF_ACK;
        end
      end
      ST_RF_ACK: begin
        if (mem_ack_i) begin
          fill_we = 1'b1;
          if (cnt_q == OW'(LINE_WORDS - 1)) begin
            valid_d[fill_idx] = 1'b1;
            tag_d[fill_idx]   = fill_tag;
            cnt_d             = '0;
            state_d           = ST_IDLE;
          end else begin
            cnt_d      = cnt_next;
            mem_req_d  = 1'b1;
            mem_addr_d = base_q | (32'(cnt_next) << 2);
            state_d    = ST_RF_REQ;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (!rst_i) begin
      accept  = 1'b0;
      hit_we  = 1'b0;
      fill_we = 1'b0;
      rd_en   = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q     <= ST_IDLE;
      valid_q     <= '0;
      cnt_q       <= '0;
      base_q      <= '0;
      mem_req_q   <= 1'b0;
      mem_wr_q    <= 4'h0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      valid_q     <= valid_d;
      cnt_q       <= cnt_d;
      base_q      <= base_d;
      mem_req_q   <= mem_req_d;
      mem_wr_q    <= mem_wr_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  // Tags need no reset: they are only consulted behind a valid bit.
  always_ff @(posedge clk_i) begin
    tag_q <= tag_d;
  end

  assign ram_accept_o = accept;
  assign mem_req_o    = mem_req_q;
  assign mem_wr_o     = mem_wr_q;
  assign mem_addr_o   = mem_addr_q;
  assign mem_wdata_o  = mem_wdata_q;

  ram_cache_data #(
    .DEPTH(LINES * LINE_WORDS),
    .AW   (IW + OW)
  ) u_data (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .hit_we_i   (hit_we),
    .hit_addr_i ({req_idx, req_off}),
    .hit_strb_i (ram_wr_i),
    .hit_data_i (ram_write_data_i),
    .fill_we_i  (fill_we),
    .fill_addr_i({fill_idx, cnt_q}),
    .fill_data_i(mem_rdata_i),
    .rd_en_i    (rd_en),
    .rd_addr_i  ({req_idx, req_off}),
    .rd_data_o  (ram_read_data_o)
  );

endmodule
